// File: rtl/cluster_periph_rr_arbiter_if.sv
// Bus bundle between the per-core periph demux outputs, the round-robin
// arbiter and the single cluster-peripheral slave plug.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding cores and slave.
interface cluster_periph_rr_arbiter_if #(
  parameter int NB_CORES   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NB_CORES-1:0]            core_req_i;
  logic [NB_CORES*ADDR_WIDTH-1:0] core_add_i;
  logic [NB_CORES-1:0]            core_we_i;
  logic [NB_CORES*DATA_WIDTH-1:0] core_wdata_i;
  logic [NB_CORES*BE_WIDTH-1:0]   core_be_i;
  logic [NB_CORES-1:0]            core_gnt_o;
  logic [NB_CORES-1:0]            core_r_valid_o;
  logic [DATA_WIDTH-1:0]          core_r_data_o;
  logic                           core_r_opc_o;

  logic                           slv_req_o;
  logic [ADDR_WIDTH-1:0]          slv_add_o;
  logic                           slv_we_o;
  logic [DATA_WIDTH-1:0]          slv_wdata_o;
  logic [BE_WIDTH-1:0]            slv_be_o;
  logic                           slv_gnt_i;
  logic                           slv_r_valid_i;
  logic [DATA_WIDTH-1:0]          slv_r_data_i;

  logic                           busy_o;

  modport slave (
    input  core_req_i, core_add_i, core_we_i, core_wdata_i, core_be_i,
    input  slv_gnt_i, slv_r_valid_i, slv_r_data_i,
    output core_gnt_o, core_r_valid_o, core_r_data_o, core_r_opc_o,
    output slv_req_o, slv_add_o, slv_we_o, slv_wdata_o, slv_be_o,
    output busy_o
  );

  modport master (
    output core_req_i, core_add_i, core_we_i, core_wdata_i, core_be_i,
    output slv_gnt_i, slv_r_valid_i, slv_r_data_i,
    input  core_gnt_o, core_r_valid_o, core_r_data_o, core_r_opc_o,
    input  slv_req_o, slv_add_o, slv_we_o, slv_wdata_o, slv_be_o,
    input  busy_o
  );
endinterface

// File: rtl/cluster_periph_rr_arbiter.sv
// Round-robin sharing of one cluster-peripheral slave port among NB_CORES
// core data ports. Only one transaction is outstanding at a time. The
// response goes back to the winning core. A WAIT-state watchdog returns an
// error response if the slave never answers.
module cluster_periph_rr_arbiter #(
  parameter int NB_CORES       = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADACCE5)
) (
  input logic clk_i,
  input logic rst_ni,
  cluster_periph_rr_arbiter_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int ID_W     = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
  // The watchdog only has to reach TIMEOUT_CYCLES. Keep at least one bit so
  // the disabled case (TIMEOUT_CYCLES == 0) still has a legal width.
  localparam int WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [ADDR_WIDTH-1:0] add_q, add_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;

  logic                  win_found;
  logic [ID_W-1:0]       win_id;
  logic [ID_W:0]         scan_sum;

  logic [ADDR_WIDTH-1:0] add_arr   [NB_CORES];
  logic [DATA_WIDTH-1:0] wdata_arr [NB_CORES];
  logic [BE_WIDTH-1:0]   be_arr    [NB_CORES];

  // Unpack the flattened per-core payload buses into per-core arrays.
  for (genvar g = 0; g < NB_CORES; g++) begin : g_unpack
    assign add_arr[g]   = bus.core_add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = bus.core_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[g]    = bus.core_be_i[g*BE_WIDTH +: BE_WIDTH];
  end

  // Pick the first requester, starting at rr_ptr and wrapping modulo NB_CORES.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    for (int k = 0; k < NB_CORES; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NB_CORES)) scan_sum = scan_sum - (ID_W+1)'(NB_CORES);
      if (!win_found && bus.core_req_i[scan_sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_sum[ID_W-1:0];
      end
    end
  end

  // Compute the next FSM state and drive the combinational grant and response outputs.
  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    id_d                = id_q;
    wdog_d              = wdog_q;
    add_d               = add_q;
    we_d                = we_q;
    wdata_d             = wdata_q;
    be_d                = be_q;
    bus.core_gnt_o      = '0;
    bus.core_r_valid_o  = '0;
    bus.core_r_data_o   = '0;
    bus.core_r_opc_o    = 1'b0;
    bus.slv_req_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          id_d    = win_id;
          add_d   = add_arr[win_id];
          we_d    = bus.core_we_i[win_id];
          wdata_d = wdata_arr[win_id];
          be_d    = be_arr[win_id];
          state_d = REQ;
        end
      end
      REQ: begin
        bus.slv_req_o        = 1'b1;
        bus.core_gnt_o[id_q] = bus.slv_gnt_i;
        if (bus.slv_gnt_i) begin
          rr_ptr_d = (id_q == ID_W'(NB_CORES - 1)) ? '0 : id_q + 1'b1;
          wdog_d   = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (wdog_q != WD_MAX) wdog_d = wdog_q + 1'b1;
        // A real response wins over a timeout that fires in the same cycle.
        if (bus.slv_r_valid_i) begin
          bus.core_r_valid_o[id_q] = 1'b1;
          bus.core_r_data_o        = bus.slv_r_data_i;
          state_d                  = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (wdog_q == WD_LIMIT)) begin
          bus.core_r_valid_o[id_q] = 1'b1;
          bus.core_r_data_o        = ERR_DATA;
          bus.core_r_opc_o         = 1'b1;
          state_d                  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold the state, the arbitration pointer, the watchdog and the latched payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      wdog_q   <= '0;
      add_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      wdog_q   <= wdog_d;
      add_q    <= add_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  assign bus.slv_add_o   = add_q;
  assign bus.slv_we_o    = we_q;
  assign bus.slv_wdata_o = wdata_q;
  assign bus.slv_be_o    = be_q;
  assign bus.busy_o      = (state_q != IDLE);

  // A slave response is only meaningful while a transaction is outstanding.
  a_rvalid_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.slv_r_valid_i |-> (state_q == WAIT));

endmodule

// File: tb/tb_cluster_periph_rr_arbiter.sv
// Scoreboard bench for cluster_periph_rr_arbiter. Expected grants and
// responses are queued when requests are raised. A negedge monitor pops them
// and compares them as the DUT produces them.
module tb_cluster_periph_rr_arbiter;
  localparam int NB = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct {
    int            id;
    logic [AW-1:0] add;
    logic          we;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } gnt_exp_t;

  typedef struct {
    logic [NB-1:0] mask;
    logic [DW-1:0] data;
    logic          opc;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  gnt_exp_t gnt_q[$];
  rsp_exp_t rsp_q[$];
  gnt_exp_t ge;
  rsp_exp_t re;
  int       remaining [NB];
  int       gnt_cyc = 0;
  int       rsp_cyc = 0;

  // slave model controls
  logic          gnt_en = 1'b1;
  logic          rsp_en = 1'b1;
  int            rsp_delay = 1;
  logic          rsp_fixed = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic [AW-1:0] addr_cap = '0;
  int            cnt = 0;

  cluster_periph_rr_arbiter_if #(.NB_CORES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cluster_periph_rr_arbiter #(
    .NB_CORES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16), .ERR_DATA(32'hBADACCE5)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.slv_gnt_i = bus.slv_req_o & gnt_en;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] core_addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  task automatic set_payload(input int i, input logic [AW-1:0] add, input logic we,
                             input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    bus.core_add_i[i*AW +: AW]   = add;
    bus.core_we_i[i]             = we;
    bus.core_wdata_i[i*DW +: DW] = wdata;
    bus.core_be_i[i*BW +: BW]    = be;
  endtask

  task automatic push_txn(input int i, input logic [AW-1:0] add, input logic we,
                          input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                          input logic [DW-1:0] data, input logic opc, input bit with_rsp);
    gnt_exp_t g;
    rsp_exp_t r;
    g.id = i; g.add = add; g.we = we; g.wdata = wdata; g.be = be;
    gnt_q.push_back(g);
    if (with_rsp) begin
      r.mask = '0; r.mask[i] = 1'b1; r.data = data; r.opc = opc;
      rsp_q.push_back(r);
    end
  endtask

  // Default transaction for core i: payload derived from i, slave echoes ~address.
  task automatic default_txn(input int i, input int n);
    set_payload(i, core_addr(i), 1'(i), 32'hC0DE_0000 | 32'(i), 4'(i + 1));
    remaining[i] = n;
  endtask

  function automatic bit no_remaining();
    for (int i = 0; i < NB; i++) if (remaining[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk); #1;
      if (gnt_q.size() == 0 && rsp_q.size() == 0 && !bus.busy_o && no_remaining()) ok = 1'b1;
    end
    check_val(tag, 64'(ok), 64'd1);
  endtask

  // Core requesters: hold req while transactions remain, drop after the last grant.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NB; i++) bus.core_req_i[i] = (remaining[i] > 0);
  end

  // Slave: capture the granted address.
  always @(negedge clk) begin
    if (bus.slv_req_o && bus.slv_gnt_i) begin
      addr_cap = bus.slv_add_o;
      if (rsp_en) cnt = rsp_delay;
    end
  end

  // Slave: respond rsp_delay cycles after the grant cycle.
  always @(posedge clk) begin
    #1;
    bus.slv_r_valid_i = 1'b0;
    bus.slv_r_data_i  = 32'hDEAD_BEEF;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        bus.slv_r_valid_i = 1'b1;
        bus.slv_r_data_i  = rsp_fixed ? rsp_data : ~addr_cap;
      end
    end
  end

  // Monitor: compare grants and responses against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.core_gnt_o != '0) begin
        check_val("gnt_onehot", 64'($onehot(bus.core_gnt_o)), 64'd1);
        if (gnt_q.size() == 0) check_val("gnt_unexpected", 64'(bus.core_gnt_o), 64'd0);
        else begin
          logic [NB-1:0] m;
          ge = gnt_q.pop_front();
          m = '0; m[ge.id] = 1'b1;
          check_val("gnt_id", 64'(bus.core_gnt_o), 64'(m));
          check_val("slv_add", 64'(bus.slv_add_o), 64'(ge.add));
          check_val("slv_we", 64'(bus.slv_we_o), 64'(ge.we));
          check_val("slv_wdata", 64'(bus.slv_wdata_o), 64'(ge.wdata));
          check_val("slv_be", 64'(bus.slv_be_o), 64'(ge.be));
        end
        gnt_cyc = cyc;
        for (int i = 0; i < NB; i++) if (bus.core_gnt_o[i] && remaining[i] > 0) remaining[i]--;
      end
      if (bus.core_r_valid_o != '0) begin
        if (rsp_q.size() == 0) check_val("rsp_unexpected", 64'(bus.core_r_valid_o), 64'd0);
        else begin
          re = rsp_q.pop_front();
          check_val("rsp_mask", 64'(bus.core_r_valid_o), 64'(re.mask));
          check_val("rsp_data", 64'(bus.core_r_data_o), 64'(re.data));
          check_val("rsp_opc", 64'(bus.core_r_opc_o), 64'(re.opc));
        end
        rsp_cyc = cyc;
      end else begin
        check_val("idle_rdata", 64'(bus.core_r_data_o), 64'd0);
        check_val("idle_opc", 64'(bus.core_r_opc_o), 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    check_val({tag, "_slv_req"}, 64'(bus.slv_req_o), 64'd0);
    check_val({tag, "_gnt"}, 64'(bus.core_gnt_o), 64'd0);
    check_val({tag, "_rvalid"}, 64'(bus.core_r_valid_o), 64'd0);
    check_val({tag, "_rdata"}, 64'(bus.core_r_data_o), 64'd0);
    check_val({tag, "_slv_add"}, 64'(bus.slv_add_o), 64'd0);
    check_val({tag, "_slv_wdata"}, 64'(bus.slv_wdata_o), 64'd0);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < NB; i++) remaining[i] = 0;
    bus.core_req_i    = '0;
    bus.core_add_i    = '0;
    bus.core_we_i     = '0;
    bus.core_wdata_i  = '0;
    bus.core_be_i     = '0;
    bus.slv_r_valid_i = 1'b0;
    bus.slv_r_data_i  = 32'hDEAD_BEEF;
    for (int i = 0; i < NB; i++) default_txn(i, 0);

    // reset state
    #12;
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // all cores request continuously: 0..7 then 0..7
    #1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NB; i++)
        push_txn(i, core_addr(i), 1'(i), 32'hC0DE_0000 | 32'(i), 4'(i + 1), ~core_addr(i), 1'b0, 1'b1);
    for (int i = 0; i < NB; i++) default_txn(i, 2);
    wait_done("all8_done", 200);

    // core 5 alone moves rr_ptr to 6, then cores 2 and 5 race: 2 wins by wrap
    @(posedge clk); #1;
    push_txn(5, core_addr(5), 1'b1, 32'hC0DE_0005, 4'd6, ~core_addr(5), 1'b0, 1'b1);
    default_txn(5, 1);
    wait_done("rr6_setup_done", 30);
    @(posedge clk); #1;
    push_txn(2, core_addr(2), 1'b0, 32'hC0DE_0002, 4'd3, ~core_addr(2), 1'b0, 1'b1);
    push_txn(5, core_addr(5), 1'b1, 32'hC0DE_0005, 4'd6, ~core_addr(5), 1'b0, 1'b1);
    default_txn(2, 1);
    default_txn(5, 1);
    wait_done("rr_wrap_done", 40);

    // single core 3 read of 0x1A10_2000: gnt in cycle 1, response in cycle 3
    @(posedge clk); #1;
    rsp_fixed = 1'b1; rsp_data = 32'h0000_1234; rsp_delay = 2;
    c0 = cyc;
    push_txn(3, 32'h1A10_2000, 1'b0, 32'h0, 4'hF, 32'h0000_1234, 1'b0, 1'b1);
    set_payload(3, 32'h1A10_2000, 1'b0, 32'h0, 4'hF);
    remaining[3] = 1;
    wait_done("t1_done", 30);
    check_val("t1_gnt_lat", 64'(gnt_cyc - c0), 64'd1);
    check_val("t1_rsp_lat", 64'(rsp_cyc - c0), 64'd3);
    rsp_fixed = 1'b0; rsp_delay = 1;

    // slave holds off the grant; payload changes after the latch are ignored
    @(posedge clk); #1;
    gnt_en = 1'b0;
    push_txn(1, core_addr(1), 1'b1, 32'hC0DE_0001, 4'd2, ~core_addr(1), 1'b0, 1'b1);
    default_txn(1, 1);
    repeat (2) @(posedge clk);
    #1 set_payload(1, 32'h2222_0000, 1'b0, 32'h1111_1111, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("hold_slv_req", 64'(bus.slv_req_o), 64'd1);
    check_val("hold_gnt", 64'(bus.core_gnt_o), 64'd0);
    check_val("hold_slv_add", 64'(bus.slv_add_o), 64'(core_addr(1)));
    @(posedge clk); #1 gnt_en = 1'b1;
    wait_done("hold_done", 30);

    // slave never responds: watchdog error response 16 cycles after the grant
    @(posedge clk); #1;
    rsp_en = 1'b0;
    push_txn(6, core_addr(6), 1'b0, 32'hC0DE_0006, 4'd7, 32'hBADACCE5, 1'b1, 1'b1);
    default_txn(6, 1);
    wait_done("timeout_done", 60);
    check_val("timeout_lat", 64'(rsp_cyc - gnt_cyc), 64'd16);
    check_val("timeout_idle", 64'(bus.busy_o), 64'd0);
    rsp_en = 1'b1;

    // response exactly when wdog == 15 is a normal response
    @(posedge clk); #1;
    rsp_fixed = 1'b1; rsp_data = 32'h5555_AAAA; rsp_delay = 16;
    push_txn(2, core_addr(2), 1'b0, 32'hC0DE_0002, 4'd3, 32'h5555_AAAA, 1'b0, 1'b1);
    default_txn(2, 1);
    wait_done("wdog15_done", 60);
    check_val("wdog15_lat", 64'(rsp_cyc - gnt_cyc), 64'd16);
    rsp_fixed = 1'b0; rsp_delay = 1;

    // reset while in WAIT aborts silently
    @(posedge clk); #1;
    rsp_en = 1'b0;
    push_txn(4, core_addr(4), 1'b0, 32'hC0DE_0004, 4'd5, 32'h0, 1'b0, 1'b0);
    default_txn(4, 1);
    for (int k = 0; k < 20 && gnt_q.size() != 0; k++) @(negedge clk);
    check_val("rst_gnt_seen", 64'(gnt_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    check_val("rst_in_wait", 64'(bus.busy_o), 64'd1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_en = 1'b1;

    // after reset rr_ptr is 0: core 0 wins over core 6
    @(posedge clk); #1;
    push_txn(0, core_addr(0), 1'b0, 32'hC0DE_0000, 4'd1, ~core_addr(0), 1'b0, 1'b1);
    push_txn(6, core_addr(6), 1'b0, 32'hC0DE_0006, 4'd7, ~core_addr(6), 1'b0, 1'b1);
    default_txn(0, 1);
    default_txn(6, 1);
    wait_done("post_rst_done", 40);

    check_val("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    check_val("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
